// File: rtl/lcd_ctrl_pkg.sv
// Shared types, address map and decode helpers for the LCD bus sequencer.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4
    } lcd_state_t;

    localparam logic [15:0] LCD_CMD_ADDR  = 16'hFF02;
    localparam logic [15:0] LCD_DATA_ADDR = 16'hFF03;
    localparam int          ENTRY_W       = 9;

    function automatic logic lcd_sel(input logic [7:0] a_hi, input logic [1:0] a_mid);
        return (a_hi == LCD_CMD_ADDR[15:8]) && (a_mid == LCD_CMD_ADDR[2:1]);
    endfunction

    // Clear display and return home need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return (rs == 1'b0) && (b[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module lcd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset discards any queued entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer for CPU writes to 0xFF02/0xFF03.
// Define LCD_4BIT_EN to send each byte as two nibbles on lcd_d[7:4].
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int T_AS       = 2,
    parameter int T_PW       = 6,
    parameter int T_H        = 2,
    parameter int T_CMD      = 48,
    parameter int T_LONG     = 1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        n_we,
    input  logic [7:0]  d,
    output logic        n_rdy,
    output logic        lcd_rs,
    output logic        lcd_e,
    output logic [7:0]  lcd_d,
    output logic        busy
);
    localparam logic [15:0] C_AS   = 16'(T_AS - 1);
    localparam logic [15:0] C_PW   = 16'(T_PW - 1);
    localparam logic [15:0] C_H    = 16'(T_H - 1);
    localparam logic [15:0] C_CMD  = 16'(T_CMD - 1);
    localparam logic [15:0] C_LONG = 16'(T_LONG - 1);

    logic               r_nwe_d;
    logic               r_pend;
    logic [ENTRY_W-1:0] r_pend_entry;
    logic               r_n_rdy;
    lcd_state_t         r_state;
    logic [15:0]        r_cnt;
    logic [7:0]         r_byte;
    logic               r_lcd_rs;
    logic               r_lcd_e;
    logic [7:0]         r_lcd_d;
    logic               r_busy;
`ifdef LCD_4BIT_EN
    logic               r_second;
`endif

    logic               w_sel;
    logic               w_wr_fall;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_rd_entry;
    logic               w_unused_a;

    assign w_sel      = lcd_sel(a[15:8], a[2:1]);
    assign w_wr_fall  = r_nwe_d & ~n_we;
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty;
    assign w_push     = r_pend & (~w_full | w_pop);
    assign w_unused_a = ^a[7:3];

    assign n_rdy  = r_n_rdy;
    assign lcd_rs = r_lcd_rs;
    assign lcd_e  = r_lcd_e;
    assign lcd_d  = r_lcd_d;
    assign busy   = r_busy;

    lcd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_pend_entry),
        .i_pop   (w_pop),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // First lane presented for a byte: high nibble in 4-bit mode, whole byte otherwise.
    function automatic logic [7:0] first_lane(input logic [7:0] b);
`ifdef LCD_4BIT_EN
        return {b[3+4:4], 4'h0};
`else
        return b;
`endif
    endfunction

    // CPU write capture into the pending slot and the registered stall line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nwe_d      <= 1'b1;
            r_pend       <= 1'b0;
            r_pend_entry <= '0;
            r_n_rdy      <= 1'b1;
        end else begin
            r_nwe_d <= n_we;
            if (w_wr_fall && w_sel && !r_pend) begin
                r_pend       <= 1'b1;
                r_pend_entry <= {a[0], d};
            end else if (w_push) begin
                r_pend <= 1'b0;
            end
            r_n_rdy <= ~(r_pend & w_full);
        end
    end

    // LCD strobe sequencer: setup, enable pulse, hold, then execution wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 16'd0;
            r_byte   <= 8'd0;
            r_lcd_rs <= 1'b0;
            r_lcd_e  <= 1'b0;
            r_lcd_d  <= 8'd0;
            r_busy   <= 1'b0;
`ifdef LCD_4BIT_EN
            r_second <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state  <= ST_SETUP;
                        r_cnt    <= C_AS;
                        r_lcd_rs <= w_rd_entry[8];
                        r_byte   <= w_rd_entry[7:0];
                        r_lcd_d  <= first_lane(w_rd_entry[7:0]);
                        r_busy   <= 1'b1;
`ifdef LCD_4BIT_EN
                        r_second <= 1'b0;
`endif
                    end else begin
                        r_busy <= w_push;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= ST_PULSE;
                        r_cnt   <= C_PW;
                        r_lcd_e <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= C_H;
                        r_lcd_e <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 16'd0) begin
`ifdef LCD_4BIT_EN
                        if (!r_second) begin
                            r_second <= 1'b1;
                            r_lcd_d  <= {r_byte[3:0], 4'h0};
                            r_state  <= ST_SETUP;
                            r_cnt    <= C_AS;
                        end else begin
                            r_state <= ST_EXEC;
                            r_cnt   <= is_long_cmd(r_lcd_rs, r_byte) ? C_LONG : C_CMD;
                        end
`else
                        r_state <= ST_EXEC;
                        r_cnt   <= is_long_cmd(r_lcd_rs, r_byte) ? C_LONG : C_CMD;
`endif
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= ~w_empty | w_push;
                    end else begin
                        r_cnt  <= r_cnt - 16'd1;
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_lcd_e <= 1'b0;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl (default and LCD_4BIT_EN builds).
`timescale 1ns/1ps
module tb_lcd_ctrl;
    import lcd_ctrl_pkg::*;

    localparam int T_AS   = 2;
    localparam int T_PW   = 6;
    localparam int T_H    = 2;
    localparam int T_CMD  = 48;
    localparam int T_LONG = 1800;
`ifdef LCD_4BIT_EN
    localparam int NIB = 2;
`else
    localparam int NIB = 1;
`endif
    localparam int NIB_EXTRA = (NIB - 1) * (T_AS + T_PW + T_H);

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic        n_we;
    logic [7:0]  d;
    logic        n_rdy;
    logic        lcd_rs;
    logic        lcd_e;
    logic [7:0]  lcd_d;
    logic        busy;

    int errors = 0;
    int checks = 0;

    lcd_ctrl #(
        .FIFO_DEPTH (4),
        .T_AS       (T_AS),
        .T_PW       (T_PW),
        .T_H        (T_H),
        .T_CMD      (T_CMD),
        .T_LONG     (T_LONG)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .n_we   (n_we),
        .d      (d),
        .n_rdy  (n_rdy),
        .lcd_rs (lcd_rs),
        .lcd_e  (lcd_e),
        .lcd_d  (lcd_d),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        a    = addr;
        d    = data;
        n_we = 1'b0;
        @(negedge clk);
        n_we = 1'b1;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (lcd_e !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (lcd_e !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Returns at the negedge where E drops after the last strobe of the byte.
    task automatic expect_byte(input string tag, input logic rs, input logic [7:0] b, output int lat);
        int w;
        wait_rise(lat);
        check({tag, "_rs"}, lcd_rs, rs);
`ifdef LCD_4BIT_EN
        check({tag, "_dhi"}, lcd_d, {b[7:4], 4'h0});
`else
        check({tag, "_d"}, lcd_d, b);
`endif
        wait_fall(w);
        check({tag, "_pw"}, w, T_PW);
`ifdef LCD_4BIT_EN
        wait_rise(w);
        check({tag, "_gap"}, w, T_H + T_AS);
        check({tag, "_rs2"}, lcd_rs, rs);
        check({tag, "_dlo"}, lcd_d, {b[3:0], 4'h0});
        wait_fall(w);
        check({tag, "_pw2"}, w, T_PW);
`endif
    endtask

    initial begin
        int n;
        int r;
        int rises;
        logic [7:0] v;

        rst  = 1'b1;
        n_we = 1'b1;
        a    = 16'h0000;
        d    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_e", lcd_e, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_d", lcd_d, 8'h00);
        check("rst_rdy", n_rdy, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        // Function set byte: latency, pulse width, exec wait.
        cpu_write(LCD_CMD_ADDR, 8'h38);
        expect_byte("t1", 1'b0, 8'h38, n);
        check("t1_lat", n, T_AS + 2);
        wait_idle(n);
        check("t1_busy_fall", n, T_H + T_CMD);

        // Clear display, then a queued byte that must wait the long exec time.
        cpu_write(LCD_CMD_ADDR, 8'h01);
        cpu_write(LCD_CMD_ADDR, 8'h80);
        expect_byte("t2a", 1'b0, 8'h01, n);
        check("t2a_lat", n, T_AS);
        expect_byte("t2b", 1'b0, 8'h80, n);
        check("t2_long_gap", n, T_H + T_LONG + 1 + T_AS);
        wait_idle(n);
        check("t2_busy_fall", n, T_H + T_CMD);

        // Data write with RS=1.
        cpu_write(LCD_DATA_ADDR, 8'h41);
        expect_byte("t3", 1'b1, 8'h41, n);
        wait_idle(n);

        // Fill the FIFO behind a clear so the fifth write stalls.
        cpu_write(LCD_CMD_ADDR, 8'h01);
        for (int k = 0; k < 5; k++) begin
            v = 8'h10 + 8'(k);
            cpu_write(LCD_DATA_ADDR, v);
        end
        check("t4_rdy_before", n_rdy, 1'b1);
        @(negedge clk);
        check("t4_rdy_low", n_rdy, 1'b0);
        r = 0;
        while (n_rdy !== 1'b1 && r < 4000) begin
            @(negedge clk);
            r++;
        end
        check("t4_rdy_release", r, 1803 + NIB_EXTRA);
        check("t4_first_rs", lcd_rs, 1'b1);
        check("t4_first_d", lcd_d, 8'h10);
        for (int k = 0; k < 5; k++) begin
            v = 8'h10 + 8'(k);
            expect_byte($sformatf("t4_b%0d", k), 1'b1, v, n);
        end
        wait_idle(n);
        check("t4_busy_fall", n, T_H + T_CMD);

        // Addresses outside the LCD decode are ignored.
        cpu_write(16'hFF06, 8'h55);
        cpu_write(16'hFE03, 8'h55);
        rises = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || lcd_e !== 1'b0) rises++;
        end
        check("t5_no_activity", rises, 0);
        check("t5_rdy", n_rdy, 1'b1);

        // Reset in the middle of the enable pulse.
        cpu_write(LCD_CMD_ADDR, 8'h38);
        wait_rise(n);
        @(negedge clk);
        @(negedge clk);
        check("t6_in_pulse", lcd_e, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_e_async", lcd_e, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_busy", busy, 1'b0);
        check("t6_rdy", n_rdy, 1'b1);
        check("t6_d", lcd_d, 8'h00);
        rises = 0;
        repeat (100) begin
            @(negedge clk);
            if (lcd_e === 1'b1) rises++;
        end
        check("t6_no_strobe", rises, 0);

        // Normal operation resumes after reset.
        cpu_write(LCD_DATA_ADDR, 8'h5A);
        expect_byte("t7", 1'b1, 8'h5A, n);
        check("t7_lat", n, T_AS + 2);
        wait_idle(n);
        check("t7_busy_fall", n, T_H + T_CMD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
